// File: rtl/receiver_pkg.sv
// Shared constants and FSM state encoding for the receive side of the four-phase CDC link.
package receiver_pkg;

    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_W   = DATA_MSB + 1;

    typedef logic [DATA_MSB:0] rx_word_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACKD = 1'b1
    } rx_state_e;

endpackage

// File: rtl/dffs.sv
// Single synchronizer flop with asynchronous active-high clear.
module dffs (
    input  logic clk,
    input  logic r,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/rxfsm.sv
// Four-phase acknowledge FSM: captures once per request, withholds ack while the output register is busy.
module rxfsm
    import receiver_pkg::*;
(
    input  logic clk_rx,
    input  logic reset,
    input  logic req_s,
    input  logic space,
    output logic ack,
    output logic cap
);

    rx_state_e state;
    rx_state_e state_nxt;

    always_ff @(posedge clk_rx or negedge reset) begin
        if (!reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        case (state)
            RX_IDLE: begin
                if (req_s && space) begin
                    cap       = 1'b1;
                    state_nxt = RX_ACKD;
                end
            end
            RX_ACKD: begin
                if (!req_s) begin
                    state_nxt = RX_IDLE;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    // ack is the state flop itself, so it reaches the transmitter glitch-free
    assign ack = (state == RX_ACKD);

endmodule

// File: rtl/receiver.sv
// Receive endpoint of the two-flop four-phase CDC link: req synchronizer, ack FSM and
// a valid/ready output register that back-pressures the link when full.
module receiver
    import receiver_pkg::*;
(
    input  logic              clk_rx,
    input  logic              reset,
    input  logic              req,
    input  logic [DATA_MSB:0] data,
    output logic              ack,
    output logic [DATA_MSB:0] rdata,
    output logic              vo,
    input  logic              rdy,
    output logic              rcv
);

    logic r1;
    logic r2;
    logic req_s;
    logic space;
    logic cap;

    dffs u_sync1 (
        .clk (clk_rx),
        .r   (!reset),
        .d   (req),
        .q   (r1)
    );

    dffs u_sync2 (
        .clk (clk_rx),
        .r   (!reset),
        .d   (r1),
        .q   (r2)
    );

    assign req_s = r2;
    // free now, or being drained by the consumer on this same edge
    assign space = !vo || rdy;

    rxfsm u_fsm (
        .clk_rx (clk_rx),
        .reset  (reset),
        .req_s  (req_s),
        .space  (space),
        .ack    (ack),
        .cap    (cap)
    );

    always_ff @(posedge clk_rx or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
            vo    <= 1'b0;
            rcv   <= 1'b0;
        end else begin
            rcv <= cap;
            if (cap) begin
                rdata <= data;
                vo    <= 1'b1;
            end else if (vo && rdy) begin
                vo <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_receiver.sv
// Directed and paired-transmitter bench for receiver with a cycle-level reference model.
`timescale 1ns/1ps
module tb_receiver;

    localparam int NW = 1000;

    logic       clk_rx = 1'b0;
    logic       clk_tx = 1'b0;
    logic       reset  = 1'b0;
    logic       rdy    = 1'b0;
    logic       d_req  = 1'b0;
    logic [7:0] d_data = 8'h00;
    logic       tx_en  = 1'b0;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       req;
    logic [7:0] data;
    logic       ack;
    logic       vo;
    logic       rcv;
    logic [7:0] rdata;
    logic       chk_en = 1'b0;
    real        tx_half = 5.0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] got [$];
    logic [7:0] words [NW];

    assign req  = tx_en ? tx_req  : d_req;
    assign data = tx_en ? tx_data : d_data;

    receiver dut (
        .clk_rx (clk_rx),
        .reset  (reset),
        .req    (req),
        .data   (data),
        .ack    (ack),
        .rdata  (rdata),
        .vo     (vo),
        .rdy    (rdy),
        .rcv    (rcv)
    );

    always #5 clk_rx = ~clk_rx;

    initial begin
        #1.7;
        forever #(tx_half) clk_tx = ~clk_tx;
    end

    // Transmitter: four-phase handshake with its own two-flop ack synchronizer
    logic a1, a2;
    int   tx_st;
    int   tx_cnt;
    logic tx_done;
    assign tx_done = (tx_cnt == NW);

    always @(posedge clk_tx or negedge reset) begin
        if (!reset) begin
            a1      <= 1'b0;
            a2      <= 1'b0;
            tx_req  <= 1'b0;
            tx_data <= 8'h00;
            tx_st   <= 0;
            tx_cnt  <= 0;
        end else begin
            a1 <= ack;
            a2 <= a1;
            if (tx_en) begin
                case (tx_st)
                    0: if (!a2 && tx_cnt < NW) begin
                        tx_data <= words[tx_cnt];
                        tx_req  <= 1'b1;
                        tx_st   <= 1;
                    end
                    1: if (a2) begin
                        tx_req <= 1'b0;
                        tx_st  <= 2;
                    end
                    default: if (!a2) begin
                        tx_cnt <= tx_cnt + 1;
                        tx_st  <= 0;
                    end
                endcase
            end
        end
    end

    // Reference model: req is seen two edges late; a word is taken when not yet
    // acknowledged, the synchronized request is up and the holding slot is free or draining.
    logic [1:0] hist;
    logic       m_ack, m_vo, m_rcv;
    logic [7:0] m_rdata;
    logic       m_reqs, m_take;
    assign m_reqs = hist[1];
    assign m_take = !m_ack && m_reqs && (!m_vo || rdy);

    always @(posedge clk_rx or negedge reset) begin
        if (!reset) begin
            hist    <= 2'b00;
            m_ack   <= 1'b0;
            m_vo    <= 1'b0;
            m_rcv   <= 1'b0;
            m_rdata <= 8'h00;
        end else begin
            hist  <= {hist[0], req};
            m_rcv <= m_take;
            m_ack <= m_ack ? m_reqs : m_take;
            m_vo  <= m_take || (m_vo && !rdy);
            if (m_take) m_rdata <= data;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_rx) begin
        if (reset && chk_en) begin
            check("cyc_ack", 32'(ack), 32'(m_ack));
            check("cyc_vo", 32'(vo), 32'(m_vo));
            check("cyc_rcv", 32'(rcv), 32'(m_rcv));
            check("cyc_rdata", 32'(rdata), 32'(m_rdata));
            if (vo && rdy) got.push_back(rdata);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_rx);
        #1;
    endtask

    task automatic wait_ack(input logic v, input int maxc, input string nm);
        int c = 0;
        while (ack !== v && c < maxc) begin
            tick(1);
            c++;
        end
        check(nm, 32'(ack), 32'(v));
    endtask

    initial begin
        logic [7:0] exp_q [$];
        int c;

        #12;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_vo", 32'(vo), 32'd0);
        check("rst_rcv", 32'(rcv), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        @(posedge clk_rx);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;

        // single transfer, rdy held low
        d_data = 8'hA5;
        d_req  = 1'b1;
        tick(2);
        check("lat_ack_e2", 32'(ack), 32'd0);
        check("lat_vo_e2", 32'(vo), 32'd0);
        tick(1);
        check("xfer_ack", 32'(ack), 32'd1);
        check("xfer_vo", 32'(vo), 32'd1);
        check("xfer_rdata", 32'(rdata), 32'hA5);
        check("xfer_rcv", 32'(rcv), 32'd1);
        tick(1);
        check("rcv_pulse_end", 32'(rcv), 32'd0);
        d_data = 8'hFF;
        tick(2);
        check("data_change_hold", 32'(rdata), 32'hA5);
        d_req = 1'b0;
        tick(2);
        check("release_ack_e2", 32'(ack), 32'd1);
        tick(1);
        check("release_ack_e3", 32'(ack), 32'd0);

        // back-pressure
        d_data = 8'h3C;
        d_req  = 1'b1;
        tick(20);
        check("bp_ack", 32'(ack), 32'd0);
        check("bp_rdata", 32'(rdata), 32'hA5);
        check("bp_vo", 32'(vo), 32'd1);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        check("bp_cap_rdata", 32'(rdata), 32'h3C);
        check("bp_cap_vo", 32'(vo), 32'd1);
        check("bp_cap_ack", 32'(ack), 32'd1);
        d_req = 1'b0;
        wait_ack(1'b0, 10, "bp_release");

        // consume and capture on the same edge
        for (int i = 0; i < 16; i++) begin
            d_data = 8'(i);
            d_req  = 1'b1;
            tick(2);
            rdy = 1'b1;
            tick(1);
            rdy = 1'b0;
            check($sformatf("coin%0d_vo", i), 32'(vo), 32'd1);
            check($sformatf("coin%0d_rdata", i), 32'(rdata), 32'(i));
            check($sformatf("coin%0d_ack", i), 32'(ack), 32'd1);
            d_req = 1'b0;
            wait_ack(1'b0, 10, "coin_release");
        end
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        tick(1);
        check("drain_vo", 32'(vo), 32'd0);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        check("dir_count", 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("dir_word%0d", i), 32'(got[i]), 32'(exp_q[i]));

        // reset mid-operation
        d_data = 8'h77;
        d_req  = 1'b1;
        wait_ack(1'b1, 10, "mid_ack_up");
        check("mid_vo_up", 32'(vo), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_vo", 32'(vo), 32'd0);
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        check("mid_rst_rcv", 32'(rcv), 32'd0);
        d_req = 1'b0;

        // paired with transmitter at three clock ratios
        for (int r = 0; r < 3; r++) begin
            reset = 1'b0;
            tx_en = 1'b0;
            rdy   = 1'b0;
            tx_half = (r == 0) ? 5.0 : ((r == 1) ? 11.667 : 2.143);
            for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
            tick(3);
            got.delete();
            reset = 1'b1;
            tx_en = 1'b1;
            c = 0;
            while (!tx_done && c < 30000) begin
                rdy = ($urandom_range(0, 3) != 0);
                tick(1);
                c++;
            end
            check($sformatf("pair%0d_done", r), 32'(tx_done), 32'd1);
            rdy = 1'b1;
            tick(4);
            rdy = 1'b0;
            check($sformatf("pair%0d_count", r), 32'(got.size()), 32'(NW));
            for (int i = 0; i < NW && i < got.size(); i++)
                check($sformatf("pair%0d_w%0d", r, i), 32'(got[i]), 32'(words[i]));
            tick(1);
            tx_en = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/receiver.md
# receiver

Receive-side endpoint of the two-flop fast four-phase clock-domain-crossing link. It sits in the `clk_rx` domain opposite the transmitter and accepts `req`/`data` from the transmit domain. `req` passes through a two-flop synchronizer, the bundled data word is captured into a local output register, and the block answers with a registered `ack` that the transmitter synchronizes on its own side. The captured word is presented to the local consumer with a valid/ready handshake; a full output register back-pressures the link by withholding `ack`.

## Interface
- `DATA_MSB`, default 7 (global constant from `def.v`): MSB index of the data word; the word is `DATA_MSB+1` bits.
- `clk_rx` in 1: receive-domain clock; all flops are rising-edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `req` in 1: four-phase request from the transmitter; asynchronous to `clk_rx`.
- `data` in `DATA_MSB+1`: bundled data from the transmitter; stable whenever `req`=1 and `ack`=0.
- `ack` out 1: four-phase acknowledge to the transmitter; driven straight from a flop.
- `rdata` out `DATA_MSB+1`: captured word.
- `vo` out 1: `rdata` valid; held until consumed.
- `rdy` in 1: consumer accepts `rdata` on a cycle where `vo`=1 and `rdy`=1.
- `rcv` out 1: one-cycle pulse on the cycle after each capture (a capture edge).

## Operation
- Synchronizer: `req` feeds flop `r1`, `r1` feeds flop `r2`, and `req_s` = `r2`. Only `req_s` is used by logic.
- `space` = `!vo | rdy`. The output register is free this cycle, or is draining this cycle.
- FSM state IDLE (`ack`=0):
  - If `req_s`=1 and `space`=1: `rdata`<=`data`, `vo`<=1, `ack`<=1, `rcv`<=1, go to ACKD.
  - If `req_s`=1 and `space`=0: stay in IDLE with `ack`=0 and `data` not sampled. This is back-pressure.
  - If `req_s`=0: stay in IDLE.
- FSM state ACKD (`ack`=1):
  - If `req_s`=0: `ack`<=0, go to IDLE.
  - Otherwise hold.
  - No capture occurs in ACKD.
- Output register:
  - `vo` clears on `vo&rdy` unless a capture happens in the same cycle.
  - When consume and capture coincide, `vo` stays 1 and `rdata` takes the new word.
- `data` is only sampled in IDLE with `req_s`=1. The protocol guarantees it has been stable for at least two `clk_rx` edges by then.
- Reset mid-operation:
  - `reset` low immediately forces `ack`=0, `vo`=0, `rcv`=0, `r1`=`r2`=0, `rdata`=0, state IDLE.
  - Both link ends are reset together at system level. A `req` still high after release is treated as a new transfer.

## Timing
- All outputs reset to 0: `ack`, `vo`, `rcv`, `rdata`, and state=IDLE.
- Link latency, with edge 1 being the first `clk_rx` edge sampling `req`=1:
  - `req_s`=1 after edge 2.
  - Capture, `ack`=1, `vo`=1 and `rcv`=1 after edge 3 (output register free).
- Release: `ack` falls at the edge after `req_s` falls, i.e. 3 edges after `req` falls.
- Minimum receiver contribution per transfer is 6 `clk_rx` cycles. The transmitter's own 2-flop `ack` synchronizer is additional.
- Consumer: `rdata`/`vo` change only at `clk_rx` edges. A word is never overwritten while `vo`=1 and `rdy`=0.
- Back-pressure: with `vo`=1 and `rdy`=0, `ack` stays 0 indefinitely. Capture occurs on the first edge where `rdy`=1 and `req_s`=1.

## Structure
- `DATA_MSB` stays in `def.v`. Add the state encodings `RX_IDLE`=1'b0 and `RX_ACKD`=1'b1 there.
- The synchronizer uses the existing `dffs` cell with an inverted `reset` (two instances).
- One sub-module, `rxfsm`:
  - Inputs: `req_s`, `space`.
  - Outputs: `ack`, `cap`.
- The top level holds the output register, the `vo` logic and the `rcv` flop.

## Test plan
- Reset and single transfer: `reset` low gives all outputs 0. Release reset, set `data`=8'hA5, raise `req`, hold `rdy`=0. Required: `ack`=1, `vo`=1, `rdata`=8'hA5 and a one-cycle `rcv` after edge 3. Dropping `req` gives `ack`=0 three edges later.
- Back-pressure: with `vo`=1 and `rdy`=0, start a second transfer with `data`=8'h3C. Required: `ack` stays 0 and `rdata` stays 8'hA5 for 20 cycles. Pulsing `rdy` for one cycle gives `rdata`=8'h3C, `vo`=1 and `ack`=1 on that edge.
- Simultaneous consume and capture: `rdy`=1 on the capture edge gives `vo` continuously 1 with `rdata` updated, and no lost or duplicated word across 16 back-to-back transfers of 0x00..0x0F.
- Data-change safety: change `data` while `ack`=1 and `req` is still high. Required: `rdata` keeps the captured value.
- Reset mid-operation: assert `reset` while in ACKD with `vo`=1. Required: `ack`, `vo` and `rdata` go to 0 asynchronously, before the next clock edge.
- Paired with transmitter: run with `clk_tx`:`clk_rx` ratios 1:1, 3:7 and 7:3 and random `rdy`, 1000 words. The received sequence must equal the sent sequence.
